// File: rtl/fft_frame_arb.sv
// Two-channel frame buffer and round-robin launcher for a shared 16-point FFT core,
// plus a result tagger that labels each transformed frame with its source channel.
module fft_frame_arb #(
    parameter int W    = 16,
    parameter int N    = 16,
    parameter int TAGD = 4
) (
    input  logic         clk,
    input  logic         i_reset_n,
    input  logic         s0_valid,
    input  logic [W-1:0] s0_re,
    input  logic [W-1:0] s0_im,
    output logic         s0_ready,
    input  logic         s1_valid,
    input  logic [W-1:0] s1_re,
    input  logic [W-1:0] s1_im,
    output logic         s1_ready,
    output logic         fft_valid,
    output logic [W-1:0] fft_re,
    output logic [W-1:0] fft_im,
    input  logic         fft_busy,
    input  logic         fft_o_valid,
    input  logic [W-1:0] fft_o_re,
    input  logic [W-1:0] fft_o_im,
    output logic         o_valid,
    output logic [W-1:0] o_re,
    output logic [W-1:0] o_im,
    output logic         o_ch,
    output logic         o_sof,
    output logic         o_eof,
    output logic         o_tag_err
);
    localparam int LN = $clog2(N);
    localparam int LT = $clog2(TAGD);
    localparam logic [LN-1:0] LAST = LN'(N - 1);

    localparam logic [1:0] FILL  = 2'd0;
    localparam logic [1:0] FULL  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    logic [1:0]    bstate [2];
    logic [LN-1:0] wcnt   [2];
    logic [W-1:0]  mem_re [2][N];
    logic [W-1:0]  mem_im [2][N];
    logic [1:0]    in_valid;
    logic [W-1:0]  in_re  [2];
    logic [W-1:0]  in_im  [2];
    logic [1:0]    is_full;

    logic [0:0]    arb_state;
    logic          cur_ch;
    logic          last_grant;
    logic [LN-1:0] rcnt;
    logic          pick;
    logic          launch;
    logic          stream_last;

    logic [LT:0]   wp;
    logic [LT:0]   rp;
    logic          tag_mem [TAGD];
    logic          tag_empty;
    logic          tag_full;
    logic          tag_head;
    logic          pop;
    logic [LN-1:0] ocnt;

    assign in_valid = {s1_valid, s0_valid};
    assign in_re[0] = s0_re;
    assign in_re[1] = s1_re;
    assign in_im[0] = s0_im;
    assign in_im[1] = s1_im;

    assign s0_ready = (bstate[0] == FILL);
    assign s1_ready = (bstate[1] == FILL);
    assign is_full  = {bstate[1] == FULL, bstate[0] == FULL};

    // On a tie the channel not served last wins; otherwise the lone full one.
    assign pick        = (&is_full) ? ~last_grant : is_full[1];
    assign launch      = (arb_state == IDLE) && (|is_full) && !fft_busy && !tag_full;
    assign stream_last = (arb_state == STREAM) && (rcnt == LAST);

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int c = 0; c < 2; c++) begin
                bstate[c] <= FILL;
                wcnt[c]   <= '0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                case (bstate[c])
                    FILL: begin
                        if (in_valid[c]) begin
                            wcnt[c] <= wcnt[c] + 1'b1;
                            if (wcnt[c] == LAST)
                                bstate[c] <= FULL;
                        end
                    end
                    FULL: begin
                        if (launch && (pick == 1'(c)))
                            bstate[c] <= DRAIN;
                    end
                    DRAIN: begin
                        if (stream_last && (cur_ch == 1'(c)))
                            bstate[c] <= FILL;
                    end
                    default: bstate[c] <= FILL;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (in_valid[c] && (bstate[c] == FILL)) begin
                mem_re[c][wcnt[c]] <= in_re[c];
                mem_im[c][wcnt[c]] <= in_im[c];
            end
        end
    end

    // Once launched, a frame streams every cycle; busy is only consulted at launch.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            arb_state  <= IDLE;
            cur_ch     <= 1'b0;
            last_grant <= 1'b1;
            rcnt       <= '0;
            fft_valid  <= 1'b0;
            fft_re     <= '0;
            fft_im     <= '0;
        end else begin
            fft_valid <= (arb_state == STREAM);
            if (arb_state == STREAM) begin
                fft_re <= mem_re[cur_ch][rcnt];
                fft_im <= mem_im[cur_ch][rcnt];
            end else begin
                fft_re <= '0;
                fft_im <= '0;
            end
            case (arb_state)
                IDLE: begin
                    if (launch) begin
                        cur_ch    <= pick;
                        rcnt      <= '0;
                        arb_state <= STREAM;
                    end
                end
                STREAM: begin
                    rcnt <= rcnt + 1'b1;
                    if (rcnt == LAST) begin
                        last_grant <= cur_ch;
                        arb_state  <= IDLE;
                    end
                end
                default: arb_state <= IDLE;
            endcase
        end
    end

    assign tag_empty = (wp == rp);
    assign tag_full  = (wp[LT] != rp[LT]) && (wp[LT-1:0] == rp[LT-1:0]);
    assign tag_head  = tag_mem[rp[LT-1:0]];
    assign pop       = fft_o_valid && (ocnt == LAST) && !tag_empty;

    always_ff @(posedge clk) begin
        if (launch)
            tag_mem[wp[LT-1:0]] <= pick;
    end

    // Results with no outstanding tag still pass through, tagged as channel 0.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wp        <= '0;
            rp        <= '0;
            ocnt      <= '0;
            o_valid   <= 1'b0;
            o_re      <= '0;
            o_im      <= '0;
            o_ch      <= 1'b0;
            o_sof     <= 1'b0;
            o_eof     <= 1'b0;
            o_tag_err <= 1'b0;
        end else begin
            if (launch)
                wp <= wp + 1'b1;
            if (pop)
                rp <= rp + 1'b1;
            o_valid <= fft_o_valid;
            o_re    <= fft_o_re;
            o_im    <= fft_o_im;
            o_ch    <= fft_o_valid && !tag_empty && tag_head;
            o_sof   <= fft_o_valid && (ocnt == '0);
            o_eof   <= fft_o_valid && (ocnt == LAST);
            if (fft_o_valid) begin
                ocnt <= ocnt + 1'b1;
                if (tag_empty)
                    o_tag_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/fft_frame_arb.md
# fft_frame_arb

Two-channel frame arbiter and sequencer for the shared `fft_16p` core. Each requester streams complex samples into a private 16-entry frame buffer. The arbiter grants completed frames round-robin and replays each one into `fft_16p` as an unbroken 16-cycle `i_valid` burst. On the output side it tags every transformed frame with its source channel and marks frame boundaries, so one FFT core serves both channels.

## Interface
- `W`, 16, sample component width (re and im each)
- `N`, 16, frame length in samples; must be a power of two and match the FFT size
- `TAGD`, 4, depth of the in-flight channel-tag FIFO; power of two
- `clk` in 1: single clock; all logic on the rising edge
- `i_reset_n` in 1: asynchronous, active-low reset
- `s0_valid` in 1: channel 0 sample valid
- `s0_re`, `s0_im` in W: channel 0 sample
- `s0_ready` out 1: channel 0 buffer accepting
- `s1_valid`, `s1_re`, `s1_im`, `s1_ready`: same as channel 0, for channel 1
- `fft_valid` out 1: drives `fft_16p.i_valid`
- `fft_re`, `fft_im` out W: drive `fft_16p.i_re` / `i_im`
- `fft_busy` in 1: from `fft_16p.o_busy`
- `fft_o_valid` in 1: from `fft_16p.o_valid`
- `fft_o_re`, `fft_o_im` in W: from `fft_16p.o_re` / `o_im`
- `o_valid` out 1: tagged result valid
- `o_re`, `o_im` out W: result sample
- `o_ch` out 1: source channel of the current result frame
- `o_sof`, `o_eof` out 1: first / last sample of a result frame
- `o_tag_err` out 1: sticky; a result arrived with no tag outstanding

## Operation
- **Per-channel buffer** has states FILL, FULL and DRAIN, plus a write counter `wcnt` with range 0..N-1.
  - `sX_ready` = (state == FILL).
  - A write occurs on `sX_valid & sX_ready` and stores the sample at `wcnt`.
  - When a write lands at `wcnt == N-1`, `wcnt` wraps to 0 and the state goes to FULL.
  - While not in FILL, `sX_valid` is ignored and the data is not stored.
- **Arbiter FSM** has states IDLE and STREAM.
  - A launch occurs in IDLE when all of these hold: at least one buffer is FULL, `fft_busy == 0`, and the tag FIFO is not full.
  - Channel choice: if both buffers are FULL, grant the channel opposite `last_grant`; otherwise grant the single FULL channel.
  - On launch: the granted buffer goes to DRAIN, its channel id is pushed into the tag FIFO, `rcnt` is set to 0, and the FSM goes to STREAM.
  - In STREAM: read `buf[rcnt]` and increment `rcnt` every cycle with no stalls. `fft_busy` is not sampled during STREAM.
  - At `rcnt == N-1`: the buffer returns to FILL, `last_grant` is set to the granted channel, and the FSM returns to IDLE.
- **Output tagger**: ocnt counts 0..N-1 on `fft_o_valid`.
  - `o_ch` = head of the tag FIFO.
  - `o_sof` = (ocnt == 0); `o_eof` = (ocnt == N-1).
  - On eof, pop the FIFO and wrap ocnt to 0.
  - A push and a pop in the same cycle leave the FIFO occupancy unchanged.
  - If `fft_o_valid` arrives while the FIFO is empty: set `o_tag_err` (cleared only by reset), still pass the data through with `o_ch` = 0, and do not pop.
- **Widths**: data is passed through unmodified with no scaling or rounding. Counters are log2(N) bits; the FIFO pointers are log2(TAGD)+1 bits.

## Timing
- **Reset values** (`i_reset_n` low, asynchronous):
  - All outputs are 0, including `fft_valid`, `fft_re`, `fft_im`, `o_valid`, `o_re`, `o_im`, `o_ch`, `o_sof`, `o_eof` and `o_tag_err`.
  - Both buffers are in FILL with `wcnt` = 0, so `sX_ready` is 1 once reset deasserts.
  - FSM is in IDLE, the tag FIFO is empty, ocnt = 0.
  - `last_grant` = 1, so channel 0 wins the first tie.
- **Input side**: the last write happens at edge t.
  - `sX_ready` is low from t+1.
  - A launch can occur at edge t+1.
  - `fft_valid` is high on cycles t+2 .. t+N+1 and is registered.
  - `fft_re`/`fft_im` carry samples 0..N-1 in write order.
- There is a minimum of one `fft_valid`-low cycle between consecutive bursts, because the FSM always passes through IDLE.
- The drained buffer is ready again the cycle after its last read. A channel may therefore begin refilling while the other channel's frame streams.
- **Output path**: registered; `o_*` follows `fft_o_*` by exactly 1 cycle. This path is independent of the input side.
- **Reset mid-operation**: a reset in STREAM or mid-fill discards all partial and in-flight frames along with their tags. No partial burst resumes after reset.

## Test plan
- **Single frame**: reset, then channel 0 supplies 16 samples with re = k and im = −k for k = 0..15, back-to-back; channel 1 stays idle.
  - Required: `s0_ready` drops after the 16th sample.
  - Required: `fft_valid` is high for exactly 16 cycles, starting 2 cycles after the last write.
  - Required: `fft_re` sequence is 0..15.
- **Contention**: both channels fill simultaneously.
  - Required: channel 0 streams first, then a gap of at least one cycle, then channel 1.
  - Required: a second simultaneous fill is granted to channel 0 again, since `last_grant` = 1.
- **Busy hold**: hold `fft_busy` = 1 while a buffer is FULL, then release it.
  - Required: no launch occurs while busy is high.
  - Required: the burst starts 1 cycle after busy falls.
  - Required: toggling busy mid-burst does not interrupt the 16-cycle burst.
- **Tagging**: stub the FFT output to return two frames of 16 `fft_o_valid` cycles, after launching ch1 then ch0.
  - Required: `o_ch` = 1 for the first 16 results and 0 for the next 16.
  - Required: `o_sof`/`o_eof` are set on results 0/15 and 16/31.
  - Required: `o_tag_err` stays 0.
- **Tag error**: `fft_o_valid` pulses with no frame launched.
  - Required: `o_tag_err` = 1 one cycle later and stays high until `i_reset_n` is asserted.
- **Backpressure and reset**:
  - Fill 4 frames with the FFT output stubbed silent. Required: the 5th FULL buffer is not launched while the tag FIFO is full.
  - Assert `i_reset_n` low mid-burst. Required: `fft_valid` = 0 immediately and both `sX_ready` = 1 after release.
